// File: rtl/des_round_sequencer.sv
// des_round_sequencer
// Runs the 16 Feistel rounds of DES, one round per clock, around an external
// combinational f-function. Holds the 16 round keys written by the SPI key
// loader and returns the pre-output block {R16,L16}; IP/FP are done elsewhere.

module des_round_sequencer #(
   parameter int NUM_ROUNDS = 16,
   parameter int KEY_W      = 48,
   parameter int BLK_W      = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   // key loader port
   input  logic                              key_wr_en,
   input  logic [KEY_W-1:0]                  key_wr_data,
   input  logic                              key_clear,
   output logic                              key_wr_ready,
   output logic                              keys_loaded,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]   key_count,
   // block input
   input  logic                              blk_valid,
   input  logic [BLK_W-1:0]                  blk_data,
   input  logic                              decrypt,
   output logic                              blk_ready,
   // f-function interface
   output logic [BLK_W/2-1:0]                round_r,
   output logic [KEY_W-1:0]                  round_key,
   input  logic [BLK_W/2-1:0]                round_f,
   // result output
   output logic                              out_valid,
   output logic [BLK_W-1:0]                  out_data,
   input  logic                              out_ready,
   // status
   output logic                              busy,
   output logic [$clog2(NUM_ROUNDS)-1:0]     round_idx
);

   localparam int HALF_W = BLK_W / 2;
   localparam int CNT_W  = $clog2(NUM_ROUNDS + 1);
   localparam int IDX_W  = $clog2(NUM_ROUNDS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ROUNDS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [KEY_W-1:0]  key_mem [NUM_ROUNDS];
   logic [HALF_W-1:0] l_q, r_q;
   logic              mode_q;
   logic [HALF_W-1:0] r_hold;
   logic [KEY_W-1:0]  key_hold;

   logic              blk_accept;
   logic              last_round;
   logic              key_write;
   logic [IDX_W-1:0]  key_sel;
   logic [KEY_W-1:0]  key_cur;
   logic [HALF_W-1:0] f_mix;

   // Key port is frozen only while rounds are consuming the store.
   assign key_wr_ready = (state_q != ROUND);
   assign keys_loaded  = (key_count == FULL_CNT);
   assign busy         = (state_q != IDLE);
   // Clear takes priority over a write in the same cycle.
   assign key_write    = key_wr_en && key_wr_ready && !key_clear && (key_count < FULL_CNT);

   // Decryption walks the schedule backwards: K16 first.
   assign key_sel = mode_q ? (LAST_IDX - round_idx) : round_idx;
   assign key_cur = key_mem[key_sel];
   assign f_mix   = l_q ^ round_f;

   // The f-function sees live state during rounds, and the last used values otherwise.
   assign round_r   = (state_q == ROUND) ? r_q     : r_hold;
   assign round_key = (state_q == ROUND) ? key_cur : key_hold;

   // State register.
   // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake decode.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      blk_ready  = 1'b0;
      blk_accept = 1'b0;
      last_round = 1'b0;
      case (state_q)
         IDLE: begin
            blk_ready = keys_loaded;
            if (blk_valid && keys_loaded) begin
               blk_accept = 1'b1;
               state_d    = ROUND;
            end
         end
         ROUND: begin
            if (round_idx == LAST_IDX) begin
               last_round = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Key counter: clear and write are only honoured outside ROUND.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_count <= '0;
      end else if (key_clear && key_wr_ready) begin
         key_count <= '0;
      end else if (key_write) begin
         key_count <= key_count + CNT_W'(1);
      end
   end

   // Round-key storage.
   // NOTE: the key array has no reset; its contents are meaningless until key_count covers them.
   always_ff @(posedge clk) begin
      if (key_write) key_mem[key_count[IDX_W-1:0]] <= key_wr_data;
   end

   // Feistel datapath, round counter and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_q       <= '0;
         r_q       <= '0;
         mode_q    <= 1'b0;
         round_idx <= '0;
         r_hold    <= '0;
         key_hold  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (blk_accept) begin
                  l_q       <= blk_data[BLK_W-1:HALF_W];
                  r_q       <= blk_data[HALF_W-1:0];
                  mode_q    <= decrypt;
                  round_idx <= '0;
               end
            end
            ROUND: begin
               l_q       <= r_q;
               r_q       <= f_mix;
               round_idx <= round_idx + IDX_W'(1);
               r_hold    <= r_q;
               key_hold  <= key_cur;
               if (last_round) begin
                  // Final swap: result is {R16, L16}.
                  out_data  <= {f_mix, r_q};
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer
// Directed sequence with random keys/blocks, checked against a loop-based
// Feistel model and a bench-side f-function (linear XOR or S-box style).

module tb_des_round_sequencer;

   logic        clk;
   logic        rst;
   logic        key_wr_en;
   logic [47:0] key_wr_data;
   logic        key_clear;
   logic        key_wr_ready;
   logic        keys_loaded;
   logic [4:0]  key_count;
   logic        blk_valid;
   logic [63:0] blk_data;
   logic        decrypt;
   logic        blk_ready;
   logic [31:0] round_r;
   logic [47:0] round_key;
   logic [31:0] round_f;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ready;
   logic        busy;
   logic [3:0]  round_idx;

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          nonlin   = 1'b0;
   logic [47:0] keys_tb [16];

   des_round_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .key_wr_en   (key_wr_en),
      .key_wr_data (key_wr_data),
      .key_clear   (key_clear),
      .key_wr_ready(key_wr_ready),
      .keys_loaded (keys_loaded),
      .key_count   (key_count),
      .blk_valid   (blk_valid),
      .blk_data    (blk_data),
      .decrypt     (decrypt),
      .blk_ready   (blk_ready),
      .round_r     (round_r),
      .round_key   (round_key),
      .round_f     (round_f),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .busy        (busy),
      .round_idx   (round_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'd14; 4'h1: sbox = 4'd4;  4'h2: sbox = 4'd13; 4'h3: sbox = 4'd1;
         4'h4: sbox = 4'd2;  4'h5: sbox = 4'd15; 4'h6: sbox = 4'd11; 4'h7: sbox = 4'd8;
         4'h8: sbox = 4'd3;  4'h9: sbox = 4'd10; 4'hA: sbox = 4'd6;  4'hB: sbox = 4'd12;
         4'hC: sbox = 4'd5;  4'hD: sbox = 4'd9;  4'hE: sbox = 4'd0;  default: sbox = 4'd7;
      endcase
   endfunction

   function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k, input bit nl);
      logic [31:0] x, y;
      if (!nl) return r ^ k[31:0];
      x = r ^ k[31:0] ^ {k[47:32], k[47:32]};
      for (int n = 0; n < 8; n++) y[n*4 +: 4] = sbox(x[n*4 +: 4]);
      return {y[20:0], y[31:21]} ^ (x >> 3);
   endfunction

   // The external f-function, modelled combinationally.
   assign round_f = f_fn(round_r, round_key, nonlin);

   // Reference: 16 Feistel rounds, result {R16,L16}.
   function automatic logic [63:0] model(input logic [63:0] blk, input bit dec, input bit nl);
      logic [31:0] l, r, t;
      l = blk[63:32];
      r = blk[31:0];
      for (int i = 0; i < 16; i++) begin
         t = l ^ f_fn(r, keys_tb[dec ? 15 - i : i], nl);
         l = r;
         r = t;
      end
      return {r, l};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_keys();
      for (int i = 0; i < 16; i++) begin
         key_wr_en   = 1'b1;
         key_wr_data = keys_tb[i];
         tick();
      end
      key_wr_en = 1'b0;
   endtask

   task automatic clear_keys();
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
   endtask

   // inject: 0 none, 1 key_clear+key_wr_en mid-ROUND, 2 key_clear in DONE
   task automatic run_block(input logic [63:0] d, input bit dec, input int hold,
                            input int inject, output logic [63:0] res);
      logic [63:0] exp;
      int          w;
      int          cnt;
      exp       = model(d, dec, nonlin);
      blk_valid = 1'b1;
      blk_data  = d;
      decrypt   = dec;
      w = 0;
      while (!blk_ready && w < 20) begin
         tick();
         w++;
      end
      tick();
      blk_valid = 1'b0;
      decrypt   = 1'b0;
      check("accept_busy", 64'(busy), 64'(1'b1));
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         if (cnt < 16) begin
            check("round_idx", 64'(round_idx), 64'(cnt));
            check("round_key", 64'(round_key), 64'(keys_tb[dec ? 15 - cnt : cnt]));
         end
         if (inject == 1 && cnt == 5) begin
            check("wr_ready_round", 64'(key_wr_ready), 64'(1'b0));
            key_clear   = 1'b1;
            key_wr_en   = 1'b1;
            key_wr_data = 48'($urandom);
         end
         if (inject == 1 && cnt == 6) begin
            key_clear = 1'b0;
            key_wr_en = 1'b0;
            check("count_round", 64'(key_count), 64'(16));
         end
         tick();
         cnt++;
      end
      check("latency", 64'(cnt), 64'(16));
      check("result", out_data, exp);
      res = out_data;
      for (int h = 0; h < hold; h++) begin
         if (inject == 2 && h == 1) key_clear = 1'b1;
         tick();
         key_clear = 1'b0;
      end
      if (hold > 0) begin
         check("hold_valid", 64'(out_valid), 64'(1'b1));
         check("hold_data", out_data, exp);
         check("hold_blk_ready", 64'(blk_ready), 64'(1'b0));
         check("hold_busy", 64'(busy), 64'(1'b1));
      end
      if (inject == 2) check("count_done_clear", 64'(key_count), 64'(0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_valid", 64'(out_valid), 64'(1'b0));
      check("release_busy", 64'(busy), 64'(1'b0));
      check("release_blk_ready", 64'(blk_ready), 64'(inject != 2));
   endtask

   initial begin
      logic [63:0] r0, r1, enc;
      logic [63:0] rnd;
      int          w;
      int          seen;

      rst = 1'b1; key_wr_en = 1'b0; key_wr_data = '0; key_clear = 1'b0;
      blk_valid = 1'b0; blk_data = '0; decrypt = 1'b0; out_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_out_valid", 64'(out_valid), 64'(1'b0));
      check("rst_busy", 64'(busy), 64'(1'b0));
      check("rst_keys_loaded", 64'(keys_loaded), 64'(1'b0));
      check("rst_key_count", 64'(key_count), 64'(0));
      check("rst_round_idx", 64'(round_idx), 64'(0));
      check("rst_out_data", out_data, 64'h0);
      check("rst_round_r", 64'(round_r), 64'(0));
      check("rst_round_key", 64'(round_key), 64'(0));
      rst = 1'b0;
      tick();
      check("nokey_blk_ready", 64'(blk_ready), 64'(1'b0));

      // Load 15 keys (K=i), then a block must not be accepted
      for (int i = 0; i < 16; i++) keys_tb[i] = 48'(i);
      for (int i = 0; i < 15; i++) begin
         key_wr_en   = 1'b1;
         key_wr_data = keys_tb[i];
         tick();
      end
      key_wr_en = 1'b0;
      check("count_15", 64'(key_count), 64'(15));
      check("loaded_15", 64'(keys_loaded), 64'(1'b0));
      blk_valid = 1'b1;
      blk_data  = {$urandom, $urandom};
      repeat (3) tick();
      check("gate_blk_ready", 64'(blk_ready), 64'(1'b0));
      check("gate_busy", 64'(busy), 64'(1'b0));
      blk_valid = 1'b0;

      // 16th key, then a 17th that must be ignored
      key_wr_en = 1'b1; key_wr_data = keys_tb[15];
      tick();
      check("count_16", 64'(key_count), 64'(16));
      check("loaded_16", 64'(keys_loaded), 64'(1'b1));
      key_wr_data = 48'hABCDEF;
      tick();
      key_wr_en = 1'b0;
      check("count_17th", 64'(key_count), 64'(16));

      // Key ordering, encrypt then decrypt of the same random block
      rnd = {$urandom, $urandom};
      run_block(rnd, 1'b0, 0, 0, r0);
      run_block(rnd, 1'b1, 0, 0, r1);

      // All-zero keys with XOR f
      clear_keys();
      check("clear_count", 64'(key_count), 64'(0));
      for (int i = 0; i < 16; i++) keys_tb[i] = '0;
      load_keys();
      run_block(64'h0123456789ABCDEF, 1'b0, 0, 0, r0);
      check("known_vector", r0, 64'h8888888889ABCDEF);

      // Random keys, nonlinear f, round trip
      clear_keys();
      for (int i = 0; i < 16; i++) keys_tb[i] = {16'($urandom), 32'($urandom)};
      load_keys();
      nonlin = 1'b1;
      run_block(64'h0123456789ABCDEF, 1'b0, 0, 0, enc);
      run_block(enc, 1'b1, 0, 0, r1);
      check("round_trip", r1, 64'h0123456789ABCDEF);

      // Backpressure for 10 cycles
      run_block({$urandom, $urandom}, 1'($urandom), 10, 0, r0);

      // Key clear/write mid-ROUND are dropped
      run_block({$urandom, $urandom}, 1'b0, 0, 1, r0);

      // Key clear in DONE: count drops, result still delivered
      run_block({$urandom, $urandom}, 1'b1, 4, 2, r0);
      check("after_done_clear_loaded", 64'(keys_loaded), 64'(1'b0));

      // Asynchronous reset at round 7
      load_keys();
      blk_valid = 1'b1;
      blk_data  = {$urandom, $urandom};
      w = 0;
      while (!blk_ready && w < 20) begin tick(); w++; end
      tick();
      blk_valid = 1'b0;
      w = 0;
      while (round_idx != 4'd7 && w < 20) begin tick(); w++; end
      check("reach_round7", 64'(round_idx), 64'(7));
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'(1'b0));
      check("mid_rst_busy", 64'(busy), 64'(1'b0));
      check("mid_rst_loaded", 64'(keys_loaded), 64'(1'b0));
      check("mid_rst_count", 64'(key_count), 64'(0));
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("no_result_after_rst", 64'(seen), 64'(0));
      check("idle_after_rst", 64'(busy), 64'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
